i2c_arbiter: RTL
================

# i2c_arbiter

Round-robin command arbiter that shares the single `i2c_master` between `NUM_REQ` on-chip requesters. It accepts per-requester read/write commands and serialises them onto the master's level-sensitive `write_en`/`read_en` inputs, which the `i2c` top converts to pulses. It then waits for `done` and returns read data and status to the granted requester. It sits between register-file or sequencer clients and the `i2c` top in master mode (`enable`=1).

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_BYTES`, 1: register address bytes.
- `DATA_BYTES`, 2: data bytes.
- `ST_WIDTH`, 1+ADDR_BYTES+DATA_BYTES: master status width.
- `TIMEOUT_CYCLES`, 65535: watchdog limit, used only with `I2C_ARB_TIMEOUT_EN`.

- `clk` in 1: system clock. One clock domain.
- `reset` in 1: asynchronous, active-high.
- `req` in NUM_REQ: per-requester command request, level, held until `ack`.
- `req_rnw` in NUM_REQ: 1 = read, 0 = write.
- `req_chip_addr` in 7*NUM_REQ: packed 7-bit target addresses, requester i at [7i+:7].
- `req_reg_addr` in 8*ADDR_BYTES*NUM_REQ: packed register addresses.
- `req_wdata` in 8*DATA_BYTES*NUM_REQ: packed write data.
- `gnt` out NUM_REQ: one-hot grant, high for the whole transaction.
- `ack` out NUM_REQ: one-cycle completion pulse to the granted requester.
- `err` out 1: valid with `ack`; 1 = timed out.
- `rdata` out 8*DATA_BYTES: read data, valid with `ack`, held until the next `ack`.
- `rstatus` out ST_WIDTH: master status captured at completion.
- `m_chip_addr` out 7, `m_reg_addr` out 8*ADDR_BYTES, `m_data_in` out 8*DATA_BYTES: registered command to the master.
- `m_write_en`, `m_read_en`, `m_write_mode` out 1: `m_write_mode` is tied to 0 (single write).
- `m_done`, `m_busy` in 1; `m_data_out` in 8*DATA_BYTES; `m_status` in ST_WIDTH: master response.

## Operation
- States:
  - IDLE: if any `req` is high, pick a requester and go to ISSUE. Otherwise stay.
  - ISSUE: drive `m_*_en` and go to WAIT_DONE.
  - WAIT_DONE: on a rising edge of `m_done`, capture the response and go to RELEASE.
  - RELEASE: pulse `ack`, drop `gnt`, return to IDLE.
- Arbitration:
  - Round-robin, starting from pointer `rr_ptr`.
  - The winner is the first set `req` at or after `rr_ptr`, wrapping past NUM_REQ-1 to 0.
  - On grant, `rr_ptr` becomes winner+1, mod NUM_REQ.
- Command capture:
  - On the IDLE→ISSUE transition, the winner's address, data and rnw are registered into `m_chip_addr`/`m_reg_addr`/`m_data_in`.
  - These values are frozen until RELEASE. Requester inputs may change afterwards without effect.
- Master enables:
  - Exactly one of `m_write_en`/`m_read_en` is high, selected by the captured rnw, from ISSUE through the `m_done` detection cycle.
  - Both are low in RELEASE and IDLE, which guarantees at least 2 low cycles between commands so the `i2c` top re-arms its edge detector.
- `m_done` edge detection:
  - A registered copy of `m_done` is kept; an edge is `m_done & ~m_done_q`.
  - A `m_done` already high on ISSUE entry is ignored until it falls and rises again.
- Completion:
  - In RELEASE, `rdata` ← `m_data_out` for reads only; writes leave `rdata` unchanged.
  - `rstatus` ← `m_status` and `err` ← 0.
- Requester dropping `req` while granted: the transaction still completes and `ack` still pulses.
- `req` still high in the cycle after `ack` is treated as a new command.
- Reset, including mid-transaction:
  - All outputs go to 0, `rr_ptr` to 0, state to IDLE.
  - The master is not otherwise aborted.
- `m_busy` is only monitored for the watchdog (see Configuration); it does not affect state transitions.

## Timing
- Cycle 0: `req` sampled in IDLE.
- Cycle 1: state = ISSUE; `gnt` and `m_*` command registers valid; `m_*_en` high.
- `m_done` rise seen at cycle N → RELEASE at N+1: `ack`/`err`/`rdata`/`rstatus` valid and `gnt` low from N+1.
- IDLE at N+2. The earliest next grant is at N+3.
- Arbitration overhead: 3 cycles per transaction on top of the master's latency.

## Configuration
- Macro: `I2C_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit-min counter clears on ISSUE and increments in WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES without a `m_done` edge: drop the enables, go to RELEASE with `err`=1.
  - `rdata` is unchanged and `rstatus` ← `m_status`.
- Undefined: no counter, WAIT_DONE waits indefinitely, `err` is constant 0.

## Structure
- Shared package `i2c_pkg`:
  - State encoding typedef: IDLE=0, ISSUE=1, WAIT_DONE=2, RELEASE=3.
  - Default width constants ADDR_BYTES/DATA_BYTES/ST_WIDTH, reused by `i2c`.
- One sub-module, `i2c_rr_picker`:
  - Purely combinational.
  - Inputs: `req`, `rr_ptr`. Outputs: one-hot winner and its index.

## Test plan
- Single write from req[2]:
  - Stimulus: chip 0x50, reg 0x01, data 0xBEEF; model `m_done` after 20 cycles.
  - Response: `m_write_en` high for cycles 1..21; `gnt`=0100; `ack[2]` at cycle 22; `err`=0.
- Read from req[0]:
  - Stimulus: model returns 0x1234.
  - Response: `rdata`=0x1234 with `ack[0]`; `m_read_en` high, `m_write_en` never high.
- Fairness with all 4 `req` held high from reset:
  - Grants in order 0,1,2,3,0.
  - Enables low for ≥2 cycles between consecutive grants.
- Stale `m_done`:
  - Stimulus: `m_done` held high when ISSUE is entered.
  - Response: no `ack` until `m_done` falls and rises again.
- Reset asserted in WAIT_DONE:
  - Response: `gnt`, `m_*_en` and `ack` go to 0 asynchronously; after release, `rr_ptr`=0 and req[0] is granted first.
- With `I2C_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=100:
  - Stimulus: never assert `m_done`.
  - Response: `ack` with `err`=1 at cycle 102; enables low from 101.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg
//   Shared definitions for the i2c block: arbiter state encoding, default
//   command/status widths (reused by the i2c top) and a helper that sizes
//   the arbiter watchdog counter.
//   No ports.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } arb_state_e;

  localparam int ADDR_BYTES = 1;
  localparam int DATA_BYTES = 2;
  localparam int ST_WIDTH   = 1 + ADDR_BYTES + DATA_BYTES;

  localparam int TO_CNT_MIN_W = 16;

  // Watchdog counter width: wide enough for the limit, never below 16 bits.
  function automatic int to_cnt_width(input int unsigned limit);
    int w;
    w = $clog2(limit + 1);
    return (w < TO_CNT_MIN_W) ? TO_CNT_MIN_W : w;
  endfunction

endpackage

// File: rtl/i2c_rr_picker.sv
// i2c_rr_picker
//   Combinational round-robin selector: the winner is the first set bit of
//   req at or after rr_ptr, wrapping from NUM_REQ-1 back to 0.
//   Ports:
//     req        in  NUM_REQ  request levels
//     rr_ptr     in  IW       search start index (must be < NUM_REQ)
//     win_onehot out NUM_REQ  one-hot winner (0 when no request)
//     win_idx    out IW       winner index
//     win_valid  out 1        at least one request present
module i2c_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IW-1:0]      win_idx,
  output logic               win_valid
);

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!win_valid && req[k]) begin
        win_valid     = 1'b1;
        win_idx       = IW'(k);
        win_onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Round-robin command arbiter sharing one i2c_master between NUM_REQ
//   requesters. Captures the winner's command, holds the level enable to the
//   master until its done rises, then pulses ack with read data and status.
//   Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort a transaction that
//   sees no done edge within TIMEOUT_CYCLES (ack with err=1).
//   Ports:
//     clk, reset                       clock, async active-high reset
//     req/req_rnw                      per-requester request level, 1=read
//     req_chip_addr/reg_addr/wdata     packed per-requester command fields
//     gnt, ack, err, rdata, rstatus    grant, completion pulse and response
//     m_chip_addr/m_reg_addr/m_data_in registered command to the master
//     m_write_en/m_read_en/m_write_mode master enables (write_mode tied 0)
//     m_done/m_busy/m_data_out/m_status master response
//
//   state        | meaning
//   -------------+-----------------------------------------------
//   ST_IDLE      | waiting for any req; picks winner, captures cmd
//   ST_ISSUE     | enable asserted, gnt valid
//   ST_WAIT_DONE | waiting for m_done rising edge (or watchdog)
//   ST_RELEASE   | ack pulse, response valid, gnt and enables low
module i2c_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter int          ADDR_BYTES     = i2c_pkg::ADDR_BYTES,
  parameter int          DATA_BYTES     = i2c_pkg::DATA_BYTES,
  parameter int          ST_WIDTH       = 1 + ADDR_BYTES + DATA_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0]                 req_rnw,
  input  logic [7*NUM_REQ-1:0]               req_chip_addr,
  input  logic [8*ADDR_BYTES*NUM_REQ-1:0]    req_reg_addr,
  input  logic [8*DATA_BYTES*NUM_REQ-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic [NUM_REQ-1:0]                 ack,
  output logic                               err,
  output logic [8*DATA_BYTES-1:0]            rdata,
  output logic [ST_WIDTH-1:0]                rstatus,
  output logic [6:0]                         m_chip_addr,
  output logic [8*ADDR_BYTES-1:0]            m_reg_addr,
  output logic [8*DATA_BYTES-1:0]            m_data_in,
  output logic                               m_write_en,
  output logic                               m_read_en,
  output logic                               m_write_mode,
  input  logic                               m_done,
  input  logic                               m_busy,
  input  logic [8*DATA_BYTES-1:0]            m_data_out,
  input  logic [ST_WIDTH-1:0]                m_status
);

  import i2c_pkg::*;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 rnw_q, rnw_d;
  logic [6:0]           chip_q, chip_d;
  logic [AW-1:0]        reg_q, reg_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [ST_WIDTH-1:0]  rstatus_q, rstatus_d;
  logic                 m_done_q;
  logic                 done_edge;

  logic [NUM_REQ-1:0]   win_onehot;
  logic [IW-1:0]        win_idx;
  logic                 win_valid;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int        CW        = to_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
`endif

  i2c_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  // A done level left high from an earlier command never looks like an edge.
  assign done_edge = m_done & ~m_done_q;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    rnw_d     = rnw_q;
    chip_d    = chip_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    rdata_d   = rdata_q;
    rstatus_d = rstatus_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d  = ST_ISSUE;
          gnt_d    = win_onehot;
          rr_ptr_d = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          rnw_d    = req_rnw[win_idx];
          chip_d   = req_chip_addr[7*win_idx +: 7];
          reg_d    = req_reg_addr[AW*win_idx +: AW];
          wdata_d  = req_wdata[DW*win_idx +: DW];
          wr_en_d  = ~req_rnw[win_idx];
          rd_en_d  = req_rnw[win_idx];
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = cnt_q + 1'b1;
`endif
      end

      ST_WAIT_DONE: begin
        if (done_edge) begin
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          ack_d     = gnt_q;
          wr_en_d   = 1'b0;
          rd_en_d   = 1'b0;
          rstatus_d = m_status;
          if (rnw_q) rdata_d = m_data_out;
`ifdef I2C_ARB_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          ack_d     = gnt_q;
          wr_en_d   = 1'b0;
          rd_en_d   = 1'b0;
          rstatus_d = m_status;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Enables drop the cycle the limit is reached, one cycle ahead of
          // the error completion.
          if (cnt_d == CNT_LIMIT) begin
            wr_en_d = 1'b0;
            rd_en_d = 1'b0;
          end
        end
`endif
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      rnw_q     <= 1'b0;
      chip_q    <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rdata_q   <= '0;
      rstatus_q <= '0;
      m_done_q  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      rnw_q     <= rnw_d;
      chip_q    <= chip_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      rdata_q   <= rdata_d;
      rstatus_q <= rstatus_d;
      m_done_q  <= m_done;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign rstatus      = rstatus_q;
  assign m_chip_addr  = chip_q;
  assign m_reg_addr   = reg_q;
  assign m_data_in    = wdata_q;
  assign m_write_en   = wr_en_q;
  assign m_read_en    = rd_en_q;
  assign m_write_mode = 1'b0;

`ifdef I2C_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // m_busy is informational only; the watchdog relies on the cycle count.
  logic unused_ok;
  assign unused_ok = &{1'b0, m_busy, TIMEOUT_CYCLES[0]};

endmodule
